// File: rtl/op_fetch.sv
// Sequential op fetcher for the 256x8 op RAM: credit-limited reads, an in-flight
// address pipeline, and an op FIFO presenting (op, op_pc) over valid/ready.
module op_fetch #(
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 2,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              hold,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_dout,
  output logic [7:0]        op,
  output logic [ADDR_W-1:0] op_pc,
  output logic              op_valid,
  input  logic              op_ready,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + READ_LAT + 1);
  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] pc_q, pc_d, cpc_q, cpc_d;
  logic [READ_LAT-1:0] sr_vld_q, sr_vld_d;
  logic [ADDR_W-1:0] sr_addr_q [READ_LAT];
  logic [ADDR_W-1:0] sr_addr_d [READ_LAT];
  logic [7:0]        fifo_op_q [DEPTH];
  logic [ADDR_W-1:0] fifo_pc_q [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     inflight_s;
  logic              issue_s, flush_s, push_s, pop_s;
  logic [7:0]        head_op_s;
  logic [ADDR_W-1:0] head_pc_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Count reads issued but not yet returned
  always_comb begin
    inflight_s = '0;
    for (int i = 0; i < READ_LAT; i++) begin
      inflight_s = inflight_s + CW'(sr_vld_q[i]);
    end
  end

  // Credit counts occupancy before any same-cycle pop, so the FIFO can never overflow
  assign issue_s   = rst & run & ~hold & ~jump & ((count_q + inflight_s) < CW'(DEPTH));
  assign flush_s   = hold | jump;
  assign push_s    = sr_vld_q[READ_LAT-1] & ~flush_s;
  assign head_op_s = fifo_op_q[rd_ptr_q];
  assign head_pc_s = fifo_pc_q[rd_ptr_q];
  assign op_valid  = (count_q != '0) & ~hold;
  assign pop_s     = op_valid & op_ready;
  assign op        = op_valid ? head_op_s : 8'h00;
  assign op_pc     = op_valid ? head_pc_s : '0;
  assign ram_re    = issue_s;
  assign ram_addr  = pc_q;
  assign pc        = pc_q;

  // Next fetch and consumer addresses
  always_comb begin
    pc_d  = pc_q;
    cpc_d = cpc_q;
    if (jump) begin
      pc_d  = jump_addr;
      cpc_d = jump_addr;
    end else if (hold) begin
      pc_d  = cpc_q;
      cpc_d = cpc_q;
    end else begin
      if (issue_s) begin
        pc_d = pc_q + ADDR_W'(1);
      end else begin
        pc_d = pc_q;
      end
      if (pop_s) begin
        cpc_d = head_pc_s + ADDR_W'(1);
      end else begin
        cpc_d = cpc_q;
      end
    end
  end

  // In-flight pipeline: stage 0 takes the issued address, the tail marks returning data
  always_comb begin
    sr_vld_d = '0;
    for (int i = 0; i < READ_LAT; i++) begin
      sr_addr_d[i] = sr_addr_q[i];
    end
    if (flush_s) begin
      sr_vld_d = '0;
    end else begin
      sr_vld_d[0]  = issue_s;
      sr_addr_d[0] = pc_q;
      for (int i = 1; i < READ_LAT; i++) begin
        sr_vld_d[i]  = sr_vld_q[i-1];
        sr_addr_d[i] = sr_addr_q[i-1];
      end
    end
  end

  // FIFO pointer and occupancy update
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_s) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(push_s) - CW'(pop_s);
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RST_PC;
      cpc_q    <= RST_PC;
      sr_vld_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        sr_addr_q[i] <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      cpc_q    <= cpc_d;
      sr_vld_q <= sr_vld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < READ_LAT; i++) begin
        sr_addr_q[i] <= sr_addr_d[i];
      end
    end
  end

  // FIFO storage: returning op captured with the address it was read from
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_op_q[i] <= 8'h00;
        fifo_pc_q[i] <= '0;
      end
    end else if (push_s) begin
      fifo_op_q[wr_ptr_q] <= ram_dout;
      fifo_pc_q[wr_ptr_q] <= sr_addr_q[READ_LAT-1];
    end else begin
      fifo_op_q[wr_ptr_q] <= fifo_op_q[wr_ptr_q];
      fifo_pc_q[wr_ptr_q] <= fifo_pc_q[wr_ptr_q];
    end
  end

endmodule

// File: tb/tb_op_fetch.sv
// Directed bench for op_fetch with a 2-cycle op RAM model; inputs and checks at negedge.
module tb_op_fetch;
  logic       clk = 1'b0;
  logic       rst, run, hold, op_ready, jump;
  logic [7:0] jump_addr, ram_addr, ram_dout, op, op_pc, pc;
  logic       ram_re, op_valid;

  logic [7:0] mem [256];
  logic [7:0] rd_s1, rd_s2;
  logic [7:0] exp_pc;
  logic [7:0] stall_op, stall_pc;
  int n_checks = 0;
  int n_fail   = 0;
  int issued   = 0;
  int popped   = 0;

  op_fetch #(.ADDR_W(8), .READ_LAT(2), .DEPTH(4), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .run(run), .hold(hold),
    .ram_re(ram_re), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .op(op), .op_pc(op_pc), .op_valid(op_valid), .op_ready(op_ready),
    .jump(jump), .jump_addr(jump_addr), .pc(pc)
  );

  always #5 clk = ~clk;

  // Op RAM with output register: data valid two cycles after ram_re
  always @(posedge clk) begin
    if (ram_re) rd_s1 <= mem[ram_addr];
    rd_s2 <= rd_s1;
  end
  assign ram_dout = rd_s2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Sample the current cycle (scoreboard on pops), then advance to the next negedge
  task automatic tick();
    #1;
    if (op_valid && op_ready) begin
      check("order_pc", 32'(op_pc), 32'(exp_pc));
      check("order_op", 32'(op), 32'(mem[exp_pc]));
      exp_pc = exp_pc + 8'd1;
      popped++;
    end
    if (ram_re) issued++;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    rst = 1'b0; run = 1'b0; hold = 1'b0; op_ready = 1'b0; jump = 1'b0; jump_addr = 8'h00;
    exp_pc = 8'h00;
    @(negedge clk); @(negedge clk);
    #1;
    check("rst_valid", 32'(op_valid), 32'd0);
    check("rst_op", 32'(op), 32'd0);
    check("rst_op_pc", 32'(op_pc), 32'd0);
    check("rst_re", 32'(ram_re), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    @(negedge clk);

    // Reset release and streaming
    rst = 1'b1; run = 1'b1; op_ready = 1'b1;
    #1;
    check("c0_re", 32'(ram_re), 32'd1);
    check("c0_addr", 32'(ram_addr), 32'd0);
    check("c0_valid", 32'(op_valid), 32'd0);
    tick();
    #1; check("c1_valid", 32'(op_valid), 32'd0);
    tick();
    #1; check("c2_valid", 32'(op_valid), 32'd0);
    tick();
    #1;
    check("c3_valid", 32'(op_valid), 32'd1);
    check("c3_op", 32'(op), 32'hA5);
    check("c3_op_pc", 32'(op_pc), 32'd0);
    for (int i = 0; i < 6; i++) tick();

    // Backpressure: FIFO fills to DEPTH, head stays stable
    op_ready = 1'b0;
    #1; stall_op = op; stall_pc = op_pc;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_valid", 32'(op_valid), 32'd1);
      check("bp_op_stable", 32'(op), 32'(stall_op));
      check("bp_pc_stable", 32'(op_pc), 32'(stall_pc));
      tick();
    end
    #1;
    check("bp_re_off", 32'(ram_re), 32'd0);
    check("bp_buffered", 32'(issued - popped), 32'd4);
    op_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1; check("bp_nogap", 32'(op_valid), 32'd1);
      tick();
    end
    for (int i = 0; i < 4; i++) tick();

    // Jump with reads in flight and ops buffered; head popped in the jump cycle
    op_ready = 1'b0;
    tick();
    op_ready = 1'b1; jump = 1'b1; jump_addr = 8'h40;
    #1; check("jmp_head_valid", 32'(op_valid), 32'd1);
    tick();
    jump = 1'b0; exp_pc = 8'h40;
    for (int i = 0; i < 3; i++) begin
      #1; check("jmp_flushed", 32'(op_valid), 32'd0);
      tick();
    end
    #1;
    check("jmp_first_valid", 32'(op_valid), 32'd1);
    check("jmp_first_pc", 32'(op_pc), 32'h40);
    for (int i = 0; i < 4; i++) tick();

    // Wrap through 8'hFF
    jump = 1'b1; jump_addr = 8'hFE;
    tick();
    jump = 1'b0; exp_pc = 8'hFE;
    for (int i = 0; i < 8; i++) tick();
    check("wrap_progress", 32'(exp_pc), 32'h03);

    // Hold with loader rewrite of RAM[5]
    jump = 1'b1; jump_addr = 8'h00;
    tick();
    jump = 1'b0; exp_pc = 8'h00;
    for (int i = 0; i < 8; i++) tick();
    check("hold_consumed", 32'(exp_pc), 32'h05);
    hold = 1'b1;
    #1;
    check("hold_valid", 32'(op_valid), 32'd0);
    check("hold_re", 32'(ram_re), 32'd0);
    mem[5] = 8'h3C;
    for (int i = 0; i < 3; i++) tick();
    hold = 1'b0;
    #1;
    check("hold_pc", 32'(pc), 32'h05);
    check("hold_re_resume", 32'(ram_re), 32'd1);
    for (int i = 0; i < 3; i++) tick();
    #1;
    check("hold_first_valid", 32'(op_valid), 32'd1);
    check("hold_first_pc", 32'(op_pc), 32'h05);
    check("hold_first_op", 32'(op), 32'h3C);
    for (int i = 0; i < 4; i++) tick();

    // Asynchronous reset mid-stream
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 32'(op_valid), 32'd0);
    check("arst_re", 32'(ram_re), 32'd0);
    check("arst_pc", 32'(pc), 32'd0);
    @(negedge clk);
    rst = 1'b1; exp_pc = 8'h00;
    #1;
    check("arst_re_restart", 32'(ram_re), 32'd1);
    check("arst_addr", 32'(ram_addr), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    #1;
    check("arst_first_valid", 32'(op_valid), 32'd1);
    check("arst_first_pc", 32'(op_pc), 32'd0);
    check("arst_first_op", 32'(op), 32'hA5);
    for (int i = 0; i < 4; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
